// File: rtl/freq_gate_ctrl_if.sv
// freq_gate_ctrl_if
//   Groups the frequency-meter sequencer's control and status signals.
//   master : environment side. It drives run and cnt_cn and observes the strobes and status.
//   slave  : controller side. It receives run and cnt_cn and drives the strobes and status.
//   Signals:
//     run     level request for continuous measurement
//     cnt_cn  carry out of the most-significant BCD stage
//     cnt_en  gate / count enable to the counter chain
//     cnt_clr one-cycle clear pulse to the counter chain
//     latch   one-cycle load strobe to the display register
//     ovf     overflow flag of the most recently latched result
//     valid   at least one result latched since reset
//     busy    sequencer not idle
interface freq_gate_ctrl_if;
   logic run;
   logic cnt_cn;
   logic cnt_en;
   logic cnt_clr;
   logic latch;
   logic ovf;
   logic valid;
   logic busy;

   modport master (
      output run, cnt_cn,
      input  cnt_en, cnt_clr, latch, ovf, valid, busy
   );

   modport slave (
      input  run, cnt_cn,
      output cnt_en, cnt_clr, latch, ovf, valid, busy
   );
endinterface

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl
//   Sequencer for the frequency-meter datapath. The counter chain goes through the phases
//   CLEAR -> GATE -> SETTLE -> LATCH -> HOLD.
//   - The counter chain is cleared, then gated for GATE_CYCLES cycles.
//   - The gate is then closed for SETTLE_CYCLES cycles so that the last carry can ripple.
//   - Next comes a one-cycle latch strobe.
//   - The result is then held for HOLD_CYCLES cycles before the next clear.
//   A rising carry from the top digit during GATE or SETTLE flags overflow. That flag is
//   reported with the latched result.
//   Ports:
//     clk  reference clock, rising edge
//     clr  synchronous active-high reset
//     bus  freq_gate_ctrl_if.slave (run, cnt_cn in; cnt_en, cnt_clr, latch, ovf, valid, busy out)
//   Optional build macro FREQ_GATE_CTRL_SYNC_EN:
//     cnt_cn goes through a two-flop synchronizer before edge detection.
//     This adds 2 cycles of latency, so SETTLE_CYCLES must be >= 3.
module freq_gate_ctrl #(
   parameter int unsigned GATE_CYCLES   = 1000,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned HOLD_CYCLES   = 3,
   parameter int unsigned CW            = 16
) (
   input  logic            clk,
   input  logic            clr,
   freq_gate_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_GATE,
      S_SETTLE,
      S_LATCH,
      S_HOLD
   } state_e;

   localparam logic [CW-1:0] ONE       = CW'(1);
   localparam logic [CW-1:0] GATE_LD   = CW'(GATE_CYCLES);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_acc_q, ovf_acc_d;
   logic          ovf_q, ovf_d;
   logic          valid_q, valid_d;
   logic          cnt_en_q, cnt_clr_q, latch_q, busy_q;
   logic          cn_s, cn_prev_q, cn_rise;

`ifdef FREQ_GATE_CTRL_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (clr) sync_q <= '0;
      else     sync_q <= {sync_q[0], bus.cnt_cn};
   end

   assign cn_s = sync_q[1];

   // A carry in the last gate cycle reaches the edge detector two cycles later.
   if (SETTLE_CYCLES < 3) begin : g_settle_chk
      $error("freq_gate_ctrl: SETTLE_CYCLES must be >= 3 with the carry synchronizer");
   end
`else
   assign cn_s = bus.cnt_cn;
`endif

   // The previous sample tracks the carry line in every state. As a result, a level that
   // is already high when GATE begins is not seen as a new edge.
   always_ff @(posedge clk) begin
      if (clr) cn_prev_q <= 1'b0;
      else     cn_prev_q <= cn_s;
   end

   assign cn_rise = cn_s & ~cn_prev_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q - ONE;
      ovf_acc_d = ovf_acc_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.run) begin
               state_d = S_CLEAR;
               cnt_d   = ONE;
            end
         end
         S_CLEAR: begin
            ovf_acc_d = 1'b0;
            state_d   = S_GATE;
            cnt_d     = GATE_LD;
         end
         S_GATE: begin
            if (cn_rise) ovf_acc_d = 1'b1;
            if (cnt_q == ONE) begin
               state_d = S_SETTLE;
               cnt_d   = SETTLE_LD;
            end
         end
         S_SETTLE: begin
            if (cn_rise) ovf_acc_d = 1'b1;
            if (cnt_q == ONE) begin
               state_d = S_LATCH;
               cnt_d   = ONE;
            end
         end
         S_LATCH: begin
            ovf_d   = ovf_acc_q;
            valid_d = 1'b1;
            if (HOLD_CYCLES != 0) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
            end else if (bus.run) begin
               state_d = S_CLEAR;
               cnt_d   = ONE;
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_HOLD: begin
            if (cnt_q == ONE) begin
               if (bus.run) begin
                  state_d = S_CLEAR;
                  cnt_d   = ONE;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Strobes are decoded from the next state. They are therefore valid in the first
   // cycle of each state.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ovf_acc_q <= 1'b0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         cnt_en_q  <= 1'b0;
         cnt_clr_q <= 1'b0;
         latch_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ovf_acc_q <= ovf_acc_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         cnt_en_q  <= (state_d == S_GATE);
         cnt_clr_q <= (state_d == S_CLEAR);
         latch_q   <= (state_d == S_LATCH);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   assign bus.cnt_en  = cnt_en_q;
   assign bus.cnt_clr = cnt_clr_q;
   assign bus.latch   = latch_q;
   assign bus.ovf     = ovf_q;
   assign bus.valid   = valid_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl
//   Randomised and scenario stimulus for freq_gate_ctrl (GATE=10, SETTLE=3, HOLD=3).
//   The reference model describes each measurement as a schedule of cycle offsets from
//   its CLEAR cycle. Overflow is taken from the carry history as the synchronizer sees it.
module tb_freq_gate_ctrl;
   localparam int G = 10;
   localparam int S = 3;
   localparam int H = 3;
   localparam int P = 1 + G + S + 1 + H;
`ifdef FREQ_GATE_CTRL_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif
   localparam int MAXC = 4096;

   typedef struct {
      int         cyc;
      logic [5:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b1;

   freq_gate_ctrl_if bus_if ();

   freq_gate_ctrl #(
      .GATE_CYCLES  (G),
      .SETTLE_CYCLES(S),
      .HOLD_CYCLES  (H),
      .CW           (16)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   bit   lat_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state.
   int   t        = 0;
   bit   model_ok = 1'b0;
   bit   m_act    = 1'b0;
   int   m_st     = 0;
   bit   m_acc    = 1'b0;
   bit   m_ovf    = 1'b0;
   bit   m_valid  = 1'b0;
   int   last_rst = -1000;
   bit   raw_h[MAXC];

   // Carry level as the edge detector sees it in cycle x. The raw history is delayed by
   // L cycles, and the pipeline reads zero until it has refilled after the last reset.
   function automatic bit view(input int x);
      if (x - L > last_rst && x - L >= 0) return raw_h[x-L];
      return 1'b0;
   endfunction

   function automatic bit edge_at(input int x);
      return view(x) && !view(x - 1);
   endfunction

   task automatic step(input bit c, input bit r, input bit n);
      exp_t e;
      int   k;
      @(posedge clk);
      #1;
      k = t - m_st;
      if (model_ok) begin
         e.cyc = t;
         e.v   = {m_act && k >= 1 && k <= G, m_act && k == 0, m_act && k == G + S + 1,
                  m_ovf, m_valid, m_act};
         exp_q.push_back(e);
         if (m_act && k == G + S + 1) lat_q.push_back(c ? 1'b0 : m_acc);
      end
      clr           = c;
      bus_if.run    = r;
      bus_if.cnt_cn = n;
      raw_h[t]      = n;
      if (c) begin
         m_act    = 1'b0;
         m_acc    = 1'b0;
         m_ovf    = 1'b0;
         m_valid  = 1'b0;
         last_rst = t;
         model_ok = 1'b1;
      end else if (m_act) begin
         if (k == 0) m_acc = 1'b0;
         else if (k <= G + S && edge_at(t)) m_acc = 1'b1;
         if (k == G + S + 1) begin
            m_ovf   = m_acc;
            m_valid = 1'b1;
         end
         if (k == P - 1) begin
            if (r) m_st = t + 1;
            else   m_act = 1'b0;
         end
      end else if (r) begin
         m_act = 1'b1;
         m_st  = t + 1;
      end
      t++;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: compares every cycle's outputs, and the ovf reported after each latch strobe.
   initial begin : monitor
      exp_t       e;
      logic [5:0] a;
      bit         pend = 1'b0;
      bit         lexp = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            checks++;
            if (bus_if.ovf !== lexp) begin
               errors++;
               $display("FAIL latch_ovf: got ovf=%b expected %b", bus_if.ovf, lexp);
            end
            pend = 1'b0;
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus_if.cnt_en, bus_if.cnt_clr, bus_if.latch, bus_if.ovf, bus_if.valid, bus_if.busy};
            checks++;
            if (a !== e.v) begin
               errors++;
               $display("FAIL outputs cycle %0d: got en,clr,latch,ovf,valid,busy=%b expected %b",
                        e.cyc, a, e.v);
            end
         end
         if (bus_if.latch === 1'b1) begin
            checks++;
            if (lat_q.size() == 0) begin
               errors++;
               $display("FAIL latch_event: got latch=1 expected no latch");
            end else begin
               lexp = lat_q.pop_front();
               pend = 1'b1;
            end
         end
      end
   end

   initial begin : driver
      bit r;
      bit n;
      bus_if.run    = 1'b0;
      bus_if.cnt_cn = 1'b0;

      // Continuous run from reset, no carry.
      do_reset();
      for (int i = 0; i < 52; i++) step(1'b0, 1'b1, 1'b0);

      // Single carry pulse in the last gate cycle, then a clean measurement.
      do_reset();
      for (int i = 0; i < 52; i++) step(1'b0, 1'b1, i == 11);

      // Carry held high from before CLEAR, with no further edge.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 26; i++) step(1'b0, i < 20, 1'b1);

      // run dropped mid-measurement.
      do_reset();
      for (int i = 0; i < 30; i++) step(1'b0, i < 5, 1'b0);

      // clr in the middle of GATE.
      do_reset();
      for (int i = 0; i < 30; i++) step(i == 8, 1'b1, 1'b0);

      // Random run / carry / occasional reset.
      r = 1'b1;
      n = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 59) == 0) r = !r;
         if ($urandom_range(0, 7) == 0)  n = !n;
         step($urandom_range(0, 299) == 0, r, n);
      end

      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);

      checks++;
      if (lat_q.size() != 0) begin
         errors++;
         $display("FAIL latch_missing: got %0d unmatched expected latches, expected 0", lat_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
